// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM state type, Rcon table, GF(2^8) arithmetic and the
// byte-permutation / column-mixing functions used by the cipher datapath.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        INIT   = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } aes_state_e;

    function automatic bit key_bits_ok(input int kb);
        return (kb == 128) || (kb == 192) || (kb == 256);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n of the block is bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] INV_EXP = 8'hfe;

    logic [7:0] inv;

    // a^254 is the inverse for a != 0 and maps 0 to 0.
    always_comb begin
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (INV_EXP[i]) inv = gf_mul(inv, a);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_cipher_param.sv
// Iterative AES-128/192/256 encryptor, one round per cycle, with a locally
// stored key schedule that can be reused across blocks.
//
// state  | meaning
// IDLE   | ready for a block, in_ready high
// KEYEXP | computing one schedule word per cycle
// INIT   | initial AddRoundKey with w[0..3]
// ROUND  | SubBytes/ShiftRows/MixColumns/AddRoundKey, round rcnt_q
// DONE   | ciphertext held on data_out until out_ready
module aes_cipher_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [255:0] key_in,
    input  logic         key_new,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         key_valid
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] LAST_K = 3'(NK - 1);
    localparam logic [3:0] NR_W   = 4'(NR);

    if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_cipher_param: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_e   state_q;
    logic [5:0]   wcnt_q;
    logic [2:0]   kpos_q;
    logic [3:0]   rci_q;
    logic [3:0]   rcnt_q;
    logic         in_ready_q, out_valid_q, busy_q, key_valid_q;
    logic [127:0] data_out_q;
    logic [127:0] st_q, st_d;
    logic [31:0]  w_q [NW];

    logic         load_key;
    logic [31:0]  w_prev, w_back, sub_word, t_word, w_new;
    logic [5:0]   rk_base;
    logic [127:0] init_key, round_key, sb_state, sr_state, mc_state, round_out;

    assign load_key = key_new || !key_valid_q;
    assign w_prev   = w_q[wcnt_q - 6'd1];
    assign w_back   = w_q[wcnt_q - NK_W];

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (.a(w_prev[31-8*g -: 8]), .y(sub_word[31-8*g -: 8]));
    end

    always_comb begin
        t_word = w_prev;
        if (kpos_q == 3'd0) begin
            t_word = {sub_word[23:0], sub_word[31:24]} ^ {rcon(rci_q), 24'h0};
        end else if (NK == 8 && kpos_q == 3'd4) begin
            t_word = sub_word;
        end
        w_new = w_back ^ t_word;
    end

    for (genvar g = 0; g < 16; g++) begin : g_subbytes
        aes_sbox u_sbox (.a(st_q[127-8*g -: 8]), .y(sb_state[127-8*g -: 8]));
    end

    assign rk_base   = {rcnt_q, 2'b00};
    assign init_key  = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign round_key = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    assign sr_state  = shift_rows(sb_state);
    assign mc_state  = {mix_column(sr_state[127:96]), mix_column(sr_state[95:64]),
                        mix_column(sr_state[63:32]),  mix_column(sr_state[31:0])};
    assign round_out = ((rcnt_q == NR_W) ? sr_state : mc_state) ^ round_key;

    always_comb begin
        st_d = st_q;
        case (state_q)
            IDLE:    if (in_valid) st_d = data_in;
            INIT:    st_d = st_q ^ init_key;
            ROUND:   st_d = round_out;
            default: st_d = st_q;
        endcase
    end

    // Block state and key schedule carry no reset; the control path gates their use.
    always_ff @(posedge clk) begin
        st_q <= st_d;
        if (state_q == IDLE && in_valid && load_key) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= key_in[255 - 32*k -: 32];
            end
        end else if (state_q == KEYEXP) begin
            w_q[wcnt_q] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            kpos_q      <= '0;
            rci_q       <= '0;
            rcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (load_key) begin
                            wcnt_q      <= NK_W;
                            kpos_q      <= 3'd0;
                            rci_q       <= 4'd1;
                            key_valid_q <= 1'b0;
                            state_q     <= KEYEXP;
                        end else begin
                            state_q <= INIT;
                        end
                    end
                end
                KEYEXP: begin
                    wcnt_q <= wcnt_q + 6'd1;
                    kpos_q <= (kpos_q == LAST_K) ? 3'd0 : kpos_q + 3'd1;
                    if (kpos_q == 3'd0) rci_q <= rci_q + 4'd1;
                    if (wcnt_q == LAST_W) begin
                        key_valid_q <= 1'b1;
                        state_q     <= INIT;
                    end
                end
                INIT: begin
                    rcnt_q  <= 4'd1;
                    state_q <= ROUND;
                end
                ROUND: begin
                    rcnt_q <= rcnt_q + 4'd1;
                    if (rcnt_q == NR_W) begin
                        data_out_q  <= round_out;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign key_valid = key_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_aes_cipher_param.sv
// Self-checking bench for aes_cipher_param: FIPS-197 vectors for all three key
// sizes, latency, key reuse, backpressure and asynchronous reset mid-operation.
module tb_aes_cipher_param;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] data_in;
    logic [255:0] key_in;
    logic         key_new, out_ready;
    logic         iv1, iv2, iv3;
    logic         ir1, ir2, ir3, ov1, ov2, ov3, bz1, bz2, bz3, kv1, kv2, kv3;
    logic [127:0] do1, do2, do3;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];

    aes_cipher_param #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .data_in(data_in),
        .key_in(key_in), .key_new(key_new), .out_valid(ov1), .out_ready(out_ready),
        .data_out(do1), .busy(bz1), .key_valid(kv1));
    aes_cipher_param #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .data_in(data_in),
        .key_in(key_in), .key_new(key_new), .out_valid(ov2), .out_ready(out_ready),
        .data_out(do2), .busy(bz2), .key_valid(kv2));
    aes_cipher_param #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .data_in(data_in),
        .key_in(key_in), .key_new(key_new), .out_valid(ov3), .out_ready(out_ready),
        .data_out(do3), .busy(bz3), .key_valid(kv3));

    int sel_mon = 3;
    logic         m_ov, m_ir, m_bz, m_kv;
    logic [127:0] m_do;
    always_comb begin
        case (sel_mon)
            1:       begin m_ov = ov1; m_ir = ir1; m_bz = bz1; m_kv = kv1; m_do = do1; end
            2:       begin m_ov = ov2; m_ir = ir2; m_bz = bz2; m_kv = kv2; m_do = do2; end
            default: begin m_ov = ov3; m_ir = ir3; m_bz = bz3; m_kv = kv3; m_do = do3; end
        endcase
    end

    // Present one block; the accepting edge E0 is the posedge inside this task.
    task automatic send(input int sel, input logic [127:0] pt, input logic [255:0] key,
                        input logic kn, input logic [127:0] expct);
        sel_mon = sel;
        @(negedge clk);
        data_in = pt;
        key_in  = key;
        key_new = kn;
        iv1 = (sel == 1);
        iv2 = (sel == 2);
        iv3 = (sel == 3);
        exp_q.push_back(expct);
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv2 = 1'b0;
        iv3 = 1'b0;
    endtask

    // Count edges after E0 until out_valid is seen; record side observations.
    task automatic wait_out(input int max_cyc, output int cyc, output logic [127:0] dat,
                            output bit timeout, output bit kv_drop, output bit busy_bad);
        cyc = 0; timeout = 0; kv_drop = 0; busy_bad = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            if (m_kv !== 1'b1) kv_drop = 1;
            if (m_bz !== !m_ir) busy_bad = 1;
            if (m_ov === 1'b1) break;
            if (cyc >= max_cyc) begin
                timeout = 1;
                break;
            end
        end
        dat = m_do;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; key_new = 1'b0;
        iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
        data_in = '0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ir3 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir3); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov3); end
        checks++; if (bz3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bz3); end
        checks++; if ({kv1, kv2, kv3} !== 3'b000) begin errors++; $display("FAIL reset_key_valid: got %b expected 000", {kv1, kv2, kv3}); end
        checks++; if (do3 !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", do3); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_nokey();
        int lat; logic [127:0] dat, e; bit to, kd, bb;
        send(3, PT, KEY256, 1'b0, CT256);
        checks++; if (ir3 !== 1'b0 || bz3 !== 1'b1) begin errors++; $display("FAIL first_nokey_accept: in_ready=%b busy=%b expected 0/1", ir3, bz3); end
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL first_nokey_timeout: no out_valid after %0d cycles", lat); end
        checks++; if (lat !== 67) begin errors++; $display("FAIL first_nokey_latency: got %0d expected 67", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL first_nokey_data: got %h expected %h", dat, e); end
        checks++; if (kv3 !== 1'b1) begin errors++; $display("FAIL first_nokey_key_valid: got %b expected 1", kv3); end
        @(posedge clk); #1;
    endtask

    task automatic test_aes128();
        int lat; logic [127:0] dat, e; bit to, kd, bb;
        send(1, PT, KEY128, 1'b1, CT128);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 51) begin errors++; $display("FAIL aes128_latency: got %0d expected 51", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL aes128_data: got %h expected %h", dat, e); end
        checks++; if (bb) begin errors++; $display("FAIL aes128_busy: busy differed from !in_ready, expected equal"); end
        @(posedge clk); #1;
    endtask

    task automatic test_aes192();
        int lat; logic [127:0] dat, e; bit to, kd, bb;
        send(2, PT, KEY192, 1'b1, CT192);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 59) begin errors++; $display("FAIL aes192_latency: got %0d expected 59", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL aes192_data: got %h expected %h", dat, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_aes256_reuse();
        int lat; logic [127:0] dat, e; bit to, kd, bb;
        send(3, PT, KEY256, 1'b1, CT256);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 67) begin errors++; $display("FAIL aes256_latency: got %0d expected 67", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL aes256_data: got %h expected %h", dat, e); end
        @(posedge clk); #1;
        checks++; if (ir3 !== 1'b1 || bz3 !== 1'b0) begin errors++; $display("FAIL aes256_release: in_ready=%b busy=%b expected 1/0", ir3, bz3); end
        send(3, PT, 256'h0, 1'b0, CT256);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 15) begin errors++; $display("FAIL reuse_latency: got %0d expected 15", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL reuse_data: got %h expected %h", dat, e); end
        checks++; if (kd) begin errors++; $display("FAIL reuse_key_valid: key_valid dropped, expected held 1"); end
        checks++; if (bb) begin errors++; $display("FAIL reuse_busy: busy differed from !in_ready, expected equal"); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; logic [127:0] dat, e; bit to, kd, bb;
        out_ready = 1'b0;
        send(3, PT, KEY256, 1'b0, CT256);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 15) begin errors++; $display("FAIL bp_latency: got %0d expected 15", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL bp_data: got %h expected %h", dat, e); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            iv3 = i[0];
            data_in = ~PT;
            key_in = 256'h0;
            key_new = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (ov3 !== 1'b1 || do3 !== e || ir3 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b data=%h expected 1/0/%h", i, ov3, ir3, do3, e);
            end
        end
        @(negedge clk);
        iv3 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (ov3 !== 1'b0 || ir3 !== 1'b1) begin errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", ov3, ir3); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ov3 !== 1'b0 || ir3 !== 1'b1) begin errors++; $display("FAIL bp_idle_after: out_valid=%b in_ready=%b expected 0/1", ov3, ir3); end
        send(3, PT, 256'h0, 1'b0, CT256);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 15) begin errors++; $display("FAIL bp_after_latency: got %0d expected 15", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL bp_after_data: got %h expected %h", dat, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [127:0] dat, e; bit to, kd, bb;
        send(3, PT, KEY256, 1'b1, CT256);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ir3 !== 1'b1 || ov3 !== 1'b0 || bz3 !== 1'b0) begin errors++; $display("FAIL rst_keyexp_ctrl: in_ready=%b out_valid=%b busy=%b expected 1/0/0", ir3, ov3, bz3); end
        checks++; if (kv3 !== 1'b0 || do3 !== 128'h0) begin errors++; $display("FAIL rst_keyexp_data: key_valid=%b data=%h expected 0/0", kv3, do3); end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        send(3, PT, KEY256, 1'b1, CT256);
        repeat (61) @(posedge clk);
        #3;
        checks++; if (kv3 !== 1'b1 || ov3 !== 1'b0) begin errors++; $display("FAIL pre_rst_round: key_valid=%b out_valid=%b expected 1/0", kv3, ov3); end
        rst_n = 1'b0;
        #1;
        checks++; if (ir3 !== 1'b1 || ov3 !== 1'b0 || bz3 !== 1'b0) begin errors++; $display("FAIL rst_round_ctrl: in_ready=%b out_valid=%b busy=%b expected 1/0/0", ir3, ov3, bz3); end
        checks++; if (kv3 !== 1'b0 || do3 !== 128'h0) begin errors++; $display("FAIL rst_round_data: key_valid=%b data=%h expected 0/0", kv3, do3); end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        send(3, PT, KEY256, 1'b0, CT256);
        wait_out(200, lat, dat, to, kd, bb);
        e = exp_q.pop_front();
        checks++; if (to || lat !== 67) begin errors++; $display("FAIL post_rst_latency: got %0d expected 67", lat); end
        checks++; if (dat !== e) begin errors++; $display("FAIL post_rst_data: got %h expected %h", dat, e); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_first_nokey();
        test_aes128();
        test_aes192();
        test_aes256_reuse();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
